// File: rtl/alu_logic_iter_if.sv
// alu_logic_iter_if -- request/result bundle for the iterative bitwise logic unit.
//
// Signals:
//   i_start            request strobe (taken only while the unit is not busy)
//   i_op[2:0]          operation select
//   i_a, i_b           WIDTH-bit operands
//   o_busy             unit is stepping through slices
//   o_done             one-cycle completion pulse
//   o_result           registered result, held until the next accepted request
//   o_zero             o_result == 0
//   o_err              illegal operation flag, held until the next accepted request
//
// Modports: master drives requests (execute-stage controller / bench),
//           slave is the logic unit itself.
interface alu_logic_iter_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_zero;
  logic             o_err;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_done, o_result, o_zero, o_err
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_done, o_result, o_zero, o_err
  );
endinterface

// File: rtl/alu_logic_iter.sv
// alu_logic_iter -- multi-cycle bitwise logic unit.
//
// Computes AND / OR / XOR / NOR / ANDN / XNOR of two WIDTH-bit operands,
// writing SLICE result bits per RUN cycle (N = WIDTH/SLICE cycles), under a
// start/done handshake. Operands and op are captured at acceptance, so the
// requester may change its inputs freely afterwards.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   bus       alu_logic_iter_if.slave (start/op/operands in, busy/done/result/zero/err out)
//
// Parameters:
//   WIDTH     operand/result width (>= 1)
//   SLICE     bits written per RUN cycle; WIDTH must be a multiple of SLICE
module alu_logic_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_logic_iter_if.slave  bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  // Full-width result of the latched operation; RUN copies one slice of it
  // per cycle into the result register.
  logic [WIDTH-1:0] full_res;

  always_comb begin
    full_res = '0;
    case (op_q)
      3'b000:  full_res = a_q & b_q;
      3'b001:  full_res = a_q | b_q;
      3'b010:  full_res = a_q ^ b_q;
      3'b011:  full_res = ~(a_q | b_q);
      3'b100:  full_res = a_q & ~b_q;
      3'b101:  full_res = ~(a_q ^ b_q);
      default: full_res = '0;
    endcase
  end

  // Per-slice write enables: slice gi is written in the RUN cycle whose
  // counter value equals gi.
  logic [N-1:0] slice_we;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice_we
      assign slice_we[gi] = (state_q == S_RUN) && (cnt_q == CW'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_RUN: begin
        // i_start is deliberately not looked at here.
        for (int s = 0; s < N; s++) begin
          if (slice_we[s]) begin
            result_d[s*SLICE +: SLICE] = full_res[s*SLICE +: SLICE];
          end
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // DONE accepts a new request exactly like IDLE so back-to-back
      // operations lose no cycle.
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          a_d      = bus.i_a;
          b_d      = bus.i_b;
          op_d     = bus.i_op;
          cnt_d    = '0;
          result_d = '0;
          if (bus.i_op[2:1] == 2'b11) begin
            // Illegal op: skip RUN, report immediately with a zero result.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_busy   = (state_q == S_RUN);
  assign bus.o_done   = (state_q == S_DONE);
  assign bus.o_result = result_q;
  assign bus.o_zero   = (result_q == '0);
  assign bus.o_err    = err_q;

endmodule
